// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encoding, line levels and the
// default bit-period derivation used by both the transmit and receive paths.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_t;

  localparam logic UART_IDLE_LEVEL = 1'b1;
  localparam logic START_LEVEL     = 1'b0;
  localparam logic STOP_LEVEL      = 1'b1;

  localparam int DEFAULT_CLK_HZ = 100_000_000;
  localparam int DEFAULT_BAUD   = 115_200;

  // Integer clocks per bit; the small rounding error is absorbed by the receiver's mid-bit sampling.
  function automatic int clks_per_bit(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

  localparam int DEFAULT_CLKS_PER_BIT = clks_per_bit(DEFAULT_CLK_HZ, DEFAULT_BAUD);

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while enabled and flags the
// terminal count. Shared between the UART transmit and receive paths.
module uart_baud_cnt #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic bit_end
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (enable) begin
      if (cnt == LAST) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  assign bit_end = enable && (cnt == LAST);

endmodule

// File: rtl/uart_tx_framer.sv
// UART transmitter: accepts a word over a valid/ready handshake and sends
// start, LSB-first data, optional parity and stop bits on a registered tx line.
module uart_tx_framer
  import uart_pkg::*;
#(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int PARITY_EN    = 1,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_start,
  output logic                 tx_ready,
  output logic                 tx_done,
  output logic                 tx
);

  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

  uart_state_t state;
  uart_state_t state_next;

  logic [DATA_BITS-1:0] shift;
  logic                 parity_bit;
  logic [BW-1:0]        bit_cnt;
  logic                 tx_reg;
  logic                 tx_next;
  logic                 accept;
  logic                 bit_end;
  logic                 last_data;
  logic                 last_stop;

  assign accept    = tx_start && (state == IDLE);
  assign last_data = (bit_cnt == LAST_DATA);
  assign last_stop = (bit_cnt == LAST_STOP);

  uart_baud_cnt #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_cnt (
    .clk    (clk),
    .rst    (rst),
    .clear  (accept),
    .enable (state != IDLE),
    .bit_end(bit_end)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = START;
      START:   if (bit_end) state_next = DATA;
      DATA:    if (bit_end && last_data) state_next = (PARITY_EN != 0) ? PARITY : STOP;
      PARITY:  if (bit_end) state_next = STOP;
      STOP:    if (bit_end && last_stop) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The line level for the next bit is resolved here and registered, so tx only moves on bit boundaries.
  always_comb begin
    tx_ready = (state == IDLE);
    tx_done  = (state == STOP) && bit_end && last_stop;
    tx_next  = tx_reg;
    if (accept) begin
      tx_next = START_LEVEL;
    end else if (bit_end) begin
      case (state_next)
        START:   tx_next = START_LEVEL;
        DATA:    tx_next = (state == DATA) ? shift[1] : shift[0];
        PARITY:  tx_next = parity_bit;
        STOP:    tx_next = STOP_LEVEL;
        default: tx_next = UART_IDLE_LEVEL;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shift      <= '0;
      parity_bit <= 1'b0;
      bit_cnt    <= '0;
      tx_reg     <= UART_IDLE_LEVEL;
    end else begin
      tx_reg <= tx_next;
      if (accept) begin
        shift      <= tx_data;
        parity_bit <= (^tx_data) ^ (PARITY_ODD != 0);
        bit_cnt    <= '0;
      end else if (bit_end) begin
        if (state == DATA) begin
          shift   <= shift >> 1;
          bit_cnt <= last_data ? '0 : bit_cnt + BW'(1);
        end else if (state == STOP) begin
          bit_cnt <= last_stop ? '0 : bit_cnt + BW'(1);
        end
      end
    end
  end

  assign tx = tx_reg;

endmodule

// File: tb/tb_uart_tx_framer.sv
// Directed bench for uart_tx_framer: four parameterisations at 4 clocks per bit,
// each frame checked cycle by cycle against hand-built bit vectors.
module tb_uart_tx_framer;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tx_data;
  logic [3:0] tx_start;
  logic [3:0] tx_ready;
  logic [3:0] tx_done;
  logic [3:0] tx_line;

  int n_compared   = 0;
  int n_mismatched = 0;

  always #5 clk = ~clk;

  uart_tx_framer #(.DATA_BITS(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_even (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_start(tx_start[0]),
    .tx_ready(tx_ready[0]), .tx_done(tx_done[0]), .tx(tx_line[0]));

  uart_tx_framer #(.DATA_BITS(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u_odd (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_start(tx_start[1]),
    .tx_ready(tx_ready[1]), .tx_done(tx_done[1]), .tx(tx_line[1]));

  uart_tx_framer #(.DATA_BITS(8), .CLKS_PER_BIT(CPB), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_nopar (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_start(tx_start[2]),
    .tx_ready(tx_ready[2]), .tx_done(tx_done[2]), .tx(tx_line[2]));

  uart_tx_framer #(.DATA_BITS(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) u_stop2 (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_start(tx_start[3]),
    .tx_ready(tx_ready[3]), .tx_done(tx_done[3]), .tx(tx_line[3]));

  task automatic checkOutput(input string tag, input logic observed, input logic expected);
    n_compared++;
    if (observed !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: observed %b, expected %b", tag, observed, expected);
    end
  endtask

  // Leaves the bench at the negedge of cycle 1 of the accepted frame.
  task automatic applyStimulus(input int inst, input logic [7:0] data, input bit hold);
    @(negedge clk);
    checkOutput($sformatf("u%0d ready before send", inst), tx_ready[inst], 1'b1);
    tx_data        = data;
    tx_start[inst] = 1'b1;
    @(negedge clk);
    if (!hold) tx_start[inst] = 1'b0;
  endtask

  // frame bit i is the i-th transmitted bit; ends at the negedge of cycle F+1.
  task automatic checkFrame(input int inst, input logic [15:0] frame, input int nbits,
                            input int change_at, input logic [7:0] change_val, input int pulse_at);
    int last_cycle = nbits * CPB;
    for (int c = 1; c <= last_cycle; c++) begin
      if (c == change_at) tx_data = change_val;
      if (pulse_at > 0 && c == pulse_at) tx_start[inst] = 1'b1;
      if (pulse_at > 0 && c == pulse_at + 1) tx_start[inst] = 1'b0;
      checkOutput($sformatf("u%0d tx c%0d", inst, c), tx_line[inst], frame[(c - 1) / CPB]);
      checkOutput($sformatf("u%0d ready c%0d", inst, c), tx_ready[inst], 1'b0);
      checkOutput($sformatf("u%0d done c%0d", inst, c), tx_done[inst], c == last_cycle);
      @(negedge clk);
    end
    checkOutput($sformatf("u%0d ready after frame", inst), tx_ready[inst], 1'b1);
    checkOutput($sformatf("u%0d tx after frame", inst), tx_line[inst], 1'b1);
    checkOutput($sformatf("u%0d done after frame", inst), tx_done[inst], 1'b0);
  endtask

  task automatic checkIdle(input int inst, input int n);
    for (int k = 0; k < n; k++) begin
      checkOutput($sformatf("u%0d idle ready %0d", inst, k), tx_ready[inst], 1'b1);
      checkOutput($sformatf("u%0d idle tx %0d", inst, k), tx_line[inst], 1'b1);
      checkOutput($sformatf("u%0d idle done %0d", inst, k), tx_done[inst], 1'b0);
      @(negedge clk);
    end
  endtask

  initial begin
    rst      = 1'b1;
    tx_data  = 8'h00;
    tx_start = 4'b0000;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("u%0d reset ready", i), tx_ready[i], 1'b1);
      checkOutput($sformatf("u%0d reset tx", i), tx_line[i], 1'b1);
      checkOutput($sformatf("u%0d reset done", i), tx_done[i], 1'b0);
    end
    rst = 1'b0;

    $display("[TB] even parity 0xA5, start pulse while busy");
    applyStimulus(0, 8'hA5, 1'b0);
    checkFrame(0, {5'b0, 1'b1, 1'b0, 8'hA5, 1'b0}, 11, 0, 8'h00, 10);
    checkIdle(0, 3);

    $display("[TB] even parity 0x01");
    applyStimulus(0, 8'h01, 1'b0);
    checkFrame(0, {5'b0, 1'b1, 1'b1, 8'h01, 1'b0}, 11, 0, 8'h00, 0);

    $display("[TB] odd parity 0x07");
    applyStimulus(1, 8'h07, 1'b0);
    checkFrame(1, {5'b0, 1'b1, 1'b0, 8'h07, 1'b0}, 11, 0, 8'h00, 0);

    $display("[TB] no parity 0x07");
    applyStimulus(2, 8'h07, 1'b0);
    checkFrame(2, {6'b0, 1'b1, 8'h07, 1'b0}, 10, 0, 8'h00, 0);

    $display("[TB] two stop bits 0xFF");
    applyStimulus(3, 8'hFF, 1'b0);
    checkFrame(3, {4'b0, 2'b11, 1'b0, 8'hFF, 1'b0}, 12, 0, 8'h00, 0);

    $display("[TB] tx_data changed mid-frame");
    applyStimulus(0, 8'h96, 1'b0);
    checkFrame(0, {5'b0, 1'b1, 1'b0, 8'h96, 1'b0}, 11, 10, 8'h00, 0);

    $display("[TB] back-to-back 0x3C then 0xC3");
    applyStimulus(0, 8'h3C, 1'b1);
    checkFrame(0, {5'b0, 1'b1, 1'b0, 8'h3C, 1'b0}, 11, 20, 8'hC3, 0);
    @(negedge clk);
    tx_start[0] = 1'b0;
    checkFrame(0, {5'b0, 1'b1, 1'b0, 8'hC3, 1'b0}, 11, 0, 8'h00, 0);
    checkIdle(0, 3);

    $display("[TB] reset at cycle 17");
    applyStimulus(0, 8'hA5, 1'b0);
    repeat (16) @(negedge clk);
    checkOutput("u0 tx c17 before reset", tx_line[0], 1'b0);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("u0 tx after abort", tx_line[0], 1'b1);
    checkOutput("u0 ready after abort", tx_ready[0], 1'b1);
    checkOutput("u0 done after abort", tx_done[0], 1'b0);
    rst = 1'b0;
    checkIdle(0, 2);
    applyStimulus(0, 8'h5A, 1'b0);
    checkFrame(0, {5'b0, 1'b1, 1'b0, 8'h5A, 1'b0}, 11, 0, 8'h00, 0);
    checkIdle(0, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
